if_id_queue: RTL and testbench

- Small in-order instruction buffer between the fetch stage and the decode stage.
- Accepts one fetched bundle per cycle from fetch: pc, instruction, extended immediate and the branch-prediction bit.
- Presents the oldest bundle to decode over a valid/ready handshake.
- Decouples fetch from decode stalls and discards all buffered wrong-path instructions on a redirect flush.

---
 rtl/if_id_queue_pkg.sv | 20 ++
 rtl/fetch_queue_ctrl.sv | 64 ++++++
 rtl/if_id_queue.sv | 91 +++++++++
 tb/tb_if_id_queue.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared fetch/decode definitions for the instruction buffer
//
// Purpose: constants and types shared between the fetch stage, the
// fetch-to-decode queue and the decode stage.
//   NOP_ENCODING   : canonical no-op (addi x0, x0, 0) shown to decode when idle
//   fetch_bundle_t : one fetched instruction with its side information
package if_id_queue_pkg;

  localparam int CPU_XLEN = 32;

  localparam logic [31:0] NOP_ENCODING = 32'h00000013;

  typedef struct packed {
    logic [CPU_XLEN-1:0] pc;
    logic [CPU_XLEN-1:0] inst;
    logic [CPU_XLEN-1:0] imm;
    logic                pred_taken;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_queue_ctrl.sv
// rtl/fetch_queue_ctrl.sv - pointer, occupancy and flush control for the fetch queue
//
// Purpose: bookkeeping half of the fetch-to-decode queue. Storage lives in
// the parent; this block decides when a write or read actually happens.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               redirect; clears pointers and occupancy, voids handshakes
//   enq_valid/enq_ready fetch-side handshake
//   deq_valid/deq_ready decode-side handshake
//   enq_fire            parent writes storage at wr_ptr when high
//   wr_ptr, rd_ptr      storage indices
//   count               number of valid entries
module fetch_queue_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  input  logic                       deq_ready,
  output logic                       enq_ready,
  output logic                       deq_valid,
  output logic                       enq_fire,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic deq_fire;

  // Ready depends only on registered occupancy: a full queue refuses a write
  // even if decode drains an entry in the same cycle.
  assign enq_ready = (count != CW'(DEPTH));
  assign deq_valid = (count != '0);

  // Flush voids both handshakes so the wrong-path bundle is never stored and
  // the consumed head is not counted.
  assign enq_fire = enq_valid & enq_ready & ~flush;
  assign deq_fire = deq_valid & deq_ready & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are exactly log2(DEPTH) wide, so the increment wraps for free.
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({enq_fire, deq_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - in-order instruction buffer between fetch and decode
//
// Purpose: buffers up to DEPTH fetched bundles and presents the oldest one to
// decode; a flush discards everything buffered. No bypass: a bundle written
// on one edge is visible to decode from the next cycle on.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   flush                    redirect / mispredict
//   enq_valid, enq_ready     fetch handshake
//   enq_pc/inst/imm/pred_taken  offered bundle
//   deq_valid, deq_ready     decode handshake
//   deq_pc/inst/imm/pred_taken  head bundle (NOP / zeros when empty)
//   count                    number of buffered bundles
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] NOP_INST = NOP_ENCODING
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [XLEN-1:0]            enq_pc,
  input  logic [XLEN-1:0]            enq_inst,
  input  logic [XLEN-1:0]            enq_imm,
  input  logic                       enq_pred_taken,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [XLEN-1:0]            deq_inst,
  output logic [XLEN-1:0]            deq_imm,
  output logic                       deq_pred_taken,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic          enq_fire;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage is deliberately not reset; the output mux hides stale contents.
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] imm_mem  [DEPTH];
  logic            pred_mem [DEPTH];

  fetch_queue_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .enq_valid (enq_valid),
    .deq_ready (deq_ready),
    .enq_ready (enq_ready),
    .deq_valid (deq_valid),
    .enq_fire  (enq_fire),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      pc_mem[wr_ptr]   <= enq_pc;
      inst_mem[wr_ptr] <= enq_inst;
      imm_mem[wr_ptr]  <= enq_imm;
      pred_mem[wr_ptr] <= enq_pred_taken;
    end
  end

  // When empty, decode sees a NOP with zeroed side fields, which also keeps
  // uninitialised storage from ever reaching the outputs.
  always_comb begin
    deq_pc         = '0;
    deq_inst       = NOP_INST;
    deq_imm        = '0;
    deq_pred_taken = 1'b0;
    if (deq_valid) begin
      deq_pc         = pc_mem[rd_ptr];
      deq_inst       = inst_mem[rd_ptr];
      deq_imm        = imm_mem[rd_ptr];
      deq_pred_taken = pred_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for the fetch-to-decode queue
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic [31:0] enq_inst;
  logic [31:0] enq_imm;
  logic        enq_pred_taken;
  logic        deq_valid;
  logic        deq_ready;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic [31:0] deq_imm;
  logic        deq_pred_taken;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  fetch_bundle_t model[$];
  logic [31:0]   got_pcs[$];
  bit            pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  if_id_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .enq_valid      (enq_valid),
    .enq_ready      (enq_ready),
    .enq_pc         (enq_pc),
    .enq_inst       (enq_inst),
    .enq_imm        (enq_imm),
    .enq_pred_taken (enq_pred_taken),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_pc         (deq_pc),
    .deq_inst       (deq_inst),
    .deq_imm        (deq_imm),
    .deq_pred_taken (deq_pred_taken),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: FIFO of accepted bundles with capacity DEPTH, emptied by
  // reset or flush; a pop happens only when something is buffered.
  always @(posedge clk) begin
    if (!rst || flush) begin
      model.delete();
    end else begin
      automatic int  n      = model.size();
      automatic bit  do_deq = (n > 0) && deq_ready;
      automatic bit  do_enq = (n < DEPTH) && enq_valid;
      automatic fetch_bundle_t b;
      b.pc = enq_pc; b.inst = enq_inst; b.imm = enq_imm; b.pred_taken = enq_pred_taken;
      if (do_deq) void'(model.pop_front());
      if (do_enq) model.push_back(b);
    end
  end

  // Monitor: every falling edge compare the DUT's view against the reference.
  always @(negedge clk) begin
    automatic bit exp_valid = (model.size() != 0);
    chk("mon_count", 32'(count), 32'(model.size()));
    chk("mon_deq_valid", 32'(deq_valid), 32'(exp_valid));
    chk("mon_enq_ready", 32'(enq_ready), 32'(model.size() < DEPTH));
    if (exp_valid) begin
      chk("mon_deq_pc", deq_pc, model[0].pc);
      chk("mon_deq_inst", deq_inst, model[0].inst);
      chk("mon_deq_imm", deq_imm, model[0].imm);
      chk("mon_deq_pred", 32'(deq_pred_taken), 32'(model[0].pred_taken));
    end else begin
      chk("mon_empty_pc", deq_pc, 32'h0);
      chk("mon_empty_inst", deq_inst, 32'h00000013);
      chk("mon_empty_imm", deq_imm, 32'h0);
      chk("mon_empty_pred", 32'(deq_pred_taken), 32'h0);
    end
    if (rst && deq_valid && deq_ready && !flush) got_pcs.push_back(deq_pc);
  end

  // Drive inputs just after an edge, then advance to 1 time unit past the next edge.
  task automatic cyc(input bit ev, input logic [31:0] pc, input logic [31:0] inst,
                     input logic [31:0] imm, input bit pt, input bit dr, input bit fl);
    enq_valid = ev; enq_pc = pc; enq_inst = inst; enq_imm = imm;
    enq_pred_taken = pt; deq_ready = dr; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    int max_count;
    bit acc;

    rst = 1'b0; flush = 1'b0; enq_valid = 1'b1; deq_ready = 1'b0;
    enq_pc = 32'h40; enq_inst = 32'h12345678; enq_imm = 32'h1; enq_pred_taken = 1'b1;

    // Reset holds the queue empty even with fetch offering.
    #3;
    chk("rst_deq_valid", 32'(deq_valid), 32'h0);
    chk("rst_deq_inst", deq_inst, 32'h00000013);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_enq_ready", 32'(enq_ready), 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_hold_count", 32'(count), 32'h0);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_valid", 32'(deq_valid), 32'h0);
    chk("post_rst_inst", deq_inst, 32'h00000013);

    // Single-entry latency.
    cyc(1, 32'h100, 32'h00A00093, 32'd10, 0, 0, 0);
    chk("lat_valid", 32'(deq_valid), 32'h1);
    chk("lat_pc", deq_pc, 32'h100);
    chk("lat_inst", deq_inst, 32'h00A00093);
    chk("lat_imm", deq_imm, 32'd10);
    chk("lat_count", 32'(count), 32'h1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    chk("lat_drain_valid", 32'(deq_valid), 32'h0);
    chk("lat_drain_count", 32'(count), 32'h0);

    // Fill to full, then one dequeue frees a slot for the held 0x10.
    got_pcs.delete();
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'hA0 + 32'(i), 32'(i), i[0], 0, 0);
    chk("full_enq_ready", 32'(enq_ready), 32'h0);
    chk("full_count", 32'(count), 32'h4);
    cyc(1, 32'h10, 32'hA4, 32'h4, 0, 0, 0);
    chk("full_reject_count", 32'(count), 32'h4);
    cyc(1, 32'h10, 32'hA4, 32'h4, 0, 1, 0);
    chk("full_deq_count", 32'(count), 32'h3);
    chk("full_deq_ready", 32'(enq_ready), 32'h1);
    cyc(1, 32'h10, 32'hA4, 32'h4, 0, 0, 0);
    chk("full_accept_count", 32'(count), 32'h4);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 0);
    chk("full_order_n", 32'(got_pcs.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_pcs.size(); i++)
      chk("full_order_pc", got_pcs[i], 32'(i * 4));

    // Wrap-around streaming with decode toggling ready.
    got_pcs.delete();
    sent = 0;
    max_count = 0;
    for (int k = 0; k < 100 && got_pcs.size() < 12; k++) begin
      enq_valid = (sent < 12);
      enq_pc = 32'(sent * 4); enq_inst = 32'h1000 + 32'(sent); enq_imm = 32'(sent);
      enq_pred_taken = 1'b0; deq_ready = pat[k % 4]; flush = 1'b0;
      acc = enq_valid && enq_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (int'(count) > max_count) max_count = int'(count);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_n", 32'(got_pcs.size()), 32'd12);
    chk("wrap_max_count_le4", 32'(max_count <= DEPTH), 32'h1);
    for (int i = 0; i < 12 && i < got_pcs.size(); i++)
      chk("wrap_order_pc", got_pcs[i], 32'(i * 4));

    // Flush wins over same-cycle enqueue and dequeue.
    got_pcs.delete();
    for (int i = 0; i < 3; i++) cyc(1, 32'h180 + 32'(i * 4), 32'h33, 32'h0, 0, 0, 0);
    chk("fl_pre_count", 32'(count), 32'h3);
    cyc(1, 32'h200, 32'h44, 32'h0, 1, 1, 1);
    chk("fl_count", 32'(count), 32'h0);
    chk("fl_valid", 32'(deq_valid), 32'h0);
    cyc(1, 32'h300, 32'h55, 32'h7, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("fl_next_n", 32'(got_pcs.size()), 32'd1);
    if (got_pcs.size() > 0) chk("fl_next_pc", got_pcs[0], 32'h300);

    // Flush while empty.
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("fl_empty_valid", 32'(deq_valid), 32'h0);

    // Asynchronous reset mid-stream.
    cyc(1, 32'h400, 32'h66, 32'h0, 0, 0, 0);
    cyc(1, 32'h404, 32'h67, 32'h0, 0, 0, 0);
    enq_valid = 1'b0;
    chk("ar_pre_count", 32'(count), 32'h2);
    #2;
    rst = 1'b0;
    model.delete();
    #1;
    chk("ar_valid", 32'(deq_valid), 32'h0);
    chk("ar_count", 32'(count), 32'h0);
    chk("ar_enq_ready", 32'(enq_ready), 32'h1);
    chk("ar_inst", deq_inst, 32'h00000013);
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomised traffic, checked entirely by the monitor.
    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom, 1'($urandom),
          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
